// File: rtl/ddr3_responder_if.sv
// User-side DDR3 command/read-data bundle between a traffic master and the responder.
// The master drives commands and write data; the responder returns read data.
interface ddr3_responder_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 22
) ();

  logic [ADDR_WIDTH-1:0]   ddr3_addr_in;
  logic                    ddr3_write_in;
  logic                    ddr3_read_in;
  logic [DATA_WIDTH/8-1:0] ddr3_byte_enable_in;
  logic [DATA_WIDTH-1:0]   ddr3_write_data_in;
  logic [DATA_WIDTH-1:0]   ddr3_rddata_o;
  logic                    ddr3_rddata_valid_o;

  modport master (
    output ddr3_addr_in,
    output ddr3_write_in,
    output ddr3_read_in,
    output ddr3_byte_enable_in,
    output ddr3_write_data_in,
    input  ddr3_rddata_o,
    input  ddr3_rddata_valid_o
  );

  modport slave (
    input  ddr3_addr_in,
    input  ddr3_write_in,
    input  ddr3_read_in,
    input  ddr3_byte_enable_in,
    input  ddr3_write_data_in,
    output ddr3_rddata_o,
    output ddr3_rddata_valid_o
  );

endinterface

// File: rtl/ddr3_responder.sv
// DDR3 user-interface responder: byte-enabled on-chip memory with a fixed-latency read pipeline,
// saturating traffic counters and a sticky read/write collision flag. Never stalls.
module ddr3_responder #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned MEM_AW       = 8,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic            usr_clk,
  input  logic            usr_rst_n,
  ddr3_responder_if.slave bus,
  output logic [31:0]     wr_count_o,
  output logic [31:0]     rd_count_o,
  output logic            collision_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** MEM_AW;

  // Command decode: a simultaneous read and write performs the write and drops the read.
  logic              wr_en;
  logic              rd_en;
  logic              coll;
  logic [MEM_AW-1:0] mem_idx;
  logic              unused_addr;

  assign wr_en       = bus.ddr3_write_in;
  assign rd_en       = bus.ddr3_read_in & ~bus.ddr3_write_in;
  assign coll        = bus.ddr3_read_in & bus.ddr3_write_in;
  assign mem_idx     = bus.ddr3_addr_in[MEM_AW-1:0];
  assign unused_addr = ^bus.ddr3_addr_in;

  // Backing store is deliberately not reset; contents are undefined until written.
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge usr_clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (bus.ddr3_byte_enable_in[b]) begin
          mem_q[mem_idx][8*b +: 8] <= bus.ddr3_write_data_in[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 captures the memory word, the last stage drives the outputs.
  // A data stage only loads when valid data arrives, so the output holds its last valid word.
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] vld_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_en;
    if (rd_en) begin
      dat_d[0] = mem_q[mem_idx];
    end
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign bus.ddr3_rddata_o       = dat_q[READ_LATENCY-1];
  assign bus.ddr3_rddata_valid_o = vld_q[READ_LATENCY-1];

  // Saturating traffic counters and sticky collision flag.
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;
  logic [31:0] rd_cnt_q;
  logic [31:0] rd_cnt_d;
  logic        coll_q;
  logic        coll_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    coll_d   = coll_q | coll;
    if (wr_en && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (rd_en && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      coll_q   <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      coll_q   <= coll_d;
    end
  end

  assign wr_count_o  = wr_cnt_q;
  assign rd_count_o  = rd_cnt_q;
  assign collision_o = coll_q;

endmodule
